// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies a debounced, clk-synchronous button level
// into SHORT / LONG / DOUBLE gestures and offers each one as a single-entry
// valid/ready event, with a sticky overflow flag for dropped events.
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES = 8,
  parameter int unsigned DOUBLE_GAP  = 6,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic       overflow,
  output logic       busy
);

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_DOUBLE = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gen_c;
  logic             pop_c;

  assign pop_c = event_valid & event_ready;

  // Gesture state and run-length counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Next-state, counter update and event generation from the current btn sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gen_c   = EV_NONE;
    unique case (state_q)
      IDLE: begin
        if (btn) begin
          state_d = PRESS1;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS1: begin
        if (btn) begin
          if (cnt_q == LONG_LAST) begin
            gen_c   = EV_LONG;
            state_d = LONG_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = WAIT2;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT2: begin
        if (btn) begin
          gen_c   = EV_DOUBLE;
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          gen_c   = EV_SHORT;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESS2, LONG_HOLD: begin
        if (!btn) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-entry event register; a full, unpopped register drops the new event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_valid <= 1'b0;
      event_code  <= EV_NONE;
      overflow    <= 1'b0;
    end else if (gen_c != EV_NONE) begin
      if (!event_valid || pop_c) begin
        event_valid <= 1'b1;
        event_code  <= gen_c;
      end else begin
        overflow <= 1'b1;
      end
    end else if (pop_c) begin
      event_valid <= 1'b0;
      event_code  <= EV_NONE;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: run-length gesture model plus directed
// scenarios with hand-computed expectations.
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int GAP  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       event_ready = 1'b0;
  logic       event_valid;
  logic [1:0] event_code;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  button_event_decoder #(.LONG_CYCLES(LONG), .DOUBLE_GAP(GAP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btn(btn), .event_ready(event_ready),
    .event_valid(event_valid), .event_code(event_code),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Gesture model: phase 0 idle, 1 first press, 2 gap, 3 wait for release.
  int         phase;
  int         run;
  bit         m_valid;
  logic [1:0] m_code;
  bit         m_ovf;

  always @(posedge clk or negedge rst) begin : model
    logic [1:0] gen;
    bit         pop;
    if (!rst) begin
      phase = 0; run = 0; m_valid = 0; m_code = 2'b00; m_ovf = 0;
    end else begin
      gen = 2'b00;
      pop = m_valid && event_ready;
      case (phase)
        0: if (btn) begin phase = 1; run = 1; end
        1: if (btn) begin
             run++;
             if (run == LONG) begin gen = 2'b10; phase = 3; end
           end else begin
             phase = 2; run = 1;
           end
        2: if (btn) begin
             gen = 2'b11; phase = 3;
           end else begin
             run++;
             if (run == GAP) begin gen = 2'b01; phase = 0; end
           end
        default: if (!btn) phase = 0;
      endcase
      if (gen != 2'b00) begin
        if (!m_valid || pop) begin m_valid = 1; m_code = gen; end
        else m_ovf = 1;
      end else if (pop) begin
        m_valid = 0; m_code = 2'b00;
      end
    end
  end

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      cmp("mon_valid", 4'(event_valid), 4'(m_valid));
      cmp("mon_code", 4'(event_code), 4'(m_code));
      cmp("mon_overflow", 4'(overflow), 4'(m_ovf));
      cmp("mon_busy", 4'(busy), 4'(phase != 0));
    end
  end

  // Drive one btn/ready sample, then return just after the edge that samples it.
  task automatic cyc(input logic b, input logic r);
    @(negedge clk);
    btn = b;
    event_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string name);
    cmp({name, "_valid"}, 4'(event_valid), 4'd0);
    cmp({name, "_code"}, 4'(event_code), 4'd0);
    cmp({name, "_overflow"}, 4'(overflow), 4'd0);
    cmp({name, "_busy"}, 4'(busy), 4'd0);
  endtask

  bit pat [15] = '{1,1,0,0,0,1,1,1,1,1,1,1,1,1,0};

  initial begin
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // 1: short press, SHORT on the 6th low sample
    repeat (3) cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    cmp("t1_pre_valid", 4'(event_valid), 4'd0);
    cyc(1'b0, 1'b1);
    cmp("t1_valid", 4'(event_valid), 4'd1);
    cmp("t1_code", 4'(event_code), 4'd1);
    cmp("t1_busy", 4'(busy), 4'd0);
    cyc(1'b0, 1'b1);
    cmp("t1_pop_valid", 4'(event_valid), 4'd0);
    cmp("t1_pop_code", 4'(event_code), 4'd0);

    // 2: 7 highs is not LONG; 8 highs is LONG, nothing more on hold/release
    repeat (7) cyc(1'b1, 1'b1);
    cmp("t2_no_long", 4'(event_valid), 4'd0);
    repeat (6) cyc(1'b0, 1'b1);
    cmp("t2_short_code", 4'(event_code), 4'd1);
    cyc(1'b0, 1'b1);
    repeat (7) cyc(1'b1, 1'b1);
    cmp("t2_pre_long", 4'(event_valid), 4'd0);
    cyc(1'b1, 1'b1);
    cmp("t2_long_valid", 4'(event_valid), 4'd1);
    cmp("t2_long_code", 4'(event_code), 4'd2);
    repeat (4) cyc(1'b1, 1'b1);
    cmp("t2_hold_valid", 4'(event_valid), 4'd0);
    cmp("t2_hold_busy", 4'(busy), 4'd1);
    repeat (8) cyc(1'b0, 1'b1);
    cmp("t2_rel_valid", 4'(event_valid), 4'd0);
    cmp("t2_rel_busy", 4'(busy), 4'd0);

    // 3: double click with a long second press
    for (int i = 0; i < 15; i++) begin
      cyc(pat[i], 1'b1);
      if (i == 5) begin
        cmp("t3_dbl_valid", 4'(event_valid), 4'd1);
        cmp("t3_dbl_code", 4'(event_code), 4'd3);
      end
      if (i == 14) cmp("t3_rel_busy", 4'(busy), 4'd0);
    end
    repeat (8) cyc(1'b0, 1'b1);
    cmp("t3_after_valid", 4'(event_valid), 4'd0);

    // 4: full register drops LONG and sets overflow
    repeat (2) cyc(1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0);
    cmp("t4_short_code", 4'(event_code), 4'd1);
    repeat (8) cyc(1'b1, 1'b0);
    cmp("t4_keep_valid", 4'(event_valid), 4'd1);
    cmp("t4_keep_code", 4'(event_code), 4'd1);
    cmp("t4_overflow", 4'(overflow), 4'd1);
    cyc(1'b1, 1'b1);
    cmp("t4_pop_valid", 4'(event_valid), 4'd0);
    cmp("t4_pop_code", 4'(event_code), 4'd0);
    cmp("t4_ovf_sticky", 4'(overflow), 4'd1);
    repeat (2) cyc(1'b0, 1'b0);

    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset("t4_rst");
    @(posedge clk);
    #3 rst = 1'b1;

    // 5: pop and refill on the same edge
    repeat (2) cyc(1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0);
    cmp("t5_short_code", 4'(event_code), 4'd1);
    repeat (7) cyc(1'b1, 1'b0);
    cmp("t5_pre_code", 4'(event_code), 4'd1);
    cyc(1'b1, 1'b1);
    cmp("t5_valid", 4'(event_valid), 4'd1);
    cmp("t5_code", 4'(event_code), 4'd2);
    cmp("t5_overflow", 4'(overflow), 4'd0);
    cyc(1'b1, 1'b1);
    cmp("t5_pop_valid", 4'(event_valid), 4'd0);
    repeat (2) cyc(1'b0, 1'b1);

    // 6: async reset mid-press with a pending event
    repeat (2) cyc(1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0);
    cmp("t6_pending", 4'(event_valid), 4'd1);
    cmp("t6_busy", 4'(busy), 4'd1);
    #2 rst = 1'b0;
    #1 chk_reset("t6_rst");
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    cmp("t6_pre_valid", 4'(event_valid), 4'd0);
    cyc(1'b0, 1'b1);
    cmp("t6_valid", 4'(event_valid), 4'd1);
    cmp("t6_code", 4'(event_code), 4'd1);
    cyc(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
